// File: rtl/addsub_share_ctrl.sv
// Round-robin controller sharing one 4-bit adder/subtractor between two requesters.
// Holds the winner's operands for SETTLE_CYCLES cycles, then captures sum, carry and overflow.
module addsub_share_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       sel0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic       sel1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       op_sel,
    input  logic [3:0] s_in,
    input  logic       cout_in,
    output logic [3:0] res,
    output logic       res_cout,
    output logic       res_ovf,
    output logic       res_id,
    output logic       res_valid,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic [3:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic       op_sel_q, op_sel_d;
    logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic [3:0] res_q, res_d;
    logic       res_cout_q, res_cout_d;
    logic       res_ovf_q, res_ovf_d;
    logic       res_id_q, res_id_d;
    logic       res_valid_q, res_valid_d;
    logic       win;

    // Signed overflow: add overflows when like-signed operands give an unlike-signed sum;
    // subtract overflows when unlike-signed operands give a result whose sign differs from A.
    function automatic logic ovf_calc(logic [3:0] a, logic [3:0] b, logic [3:0] s, logic sub);
        if (sub)
            return (a[3] != b[3]) && (s[3] != a[3]);
        else
            return (a[3] == b[3]) && (s[3] != a[3]);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sel_q    <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_q       <= '0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sel_q    <= op_sel_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            res_q       <= res_d;
            res_cout_q  <= res_cout_d;
            res_ovf_q   <= res_ovf_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sel_d    = op_sel_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        res_d       = res_q;
        res_cout_d  = res_cout_q;
        res_ovf_d   = res_ovf_q;
        res_id_d    = res_id_q;
        res_valid_d = 1'b0;
        // On a tie the channel that was not served last wins.
        win         = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    op_a_d   = win ? a1 : a0;
                    op_b_d   = win ? b1 : b0;
                    op_sel_d = win ? sel1 : sel0;
                    gnt0_d   = ~win;
                    gnt1_d   = win;
                    res_id_d = win;
                    cnt_d    = SETTLE_LD;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd1) begin
                    res_d       = s_in;
                    res_cout_d  = cout_in;
                    res_ovf_d   = ovf_calc(op_a_q, op_b_q, s_in, op_sel_q);
                    res_valid_d = 1'b1;
                    last_d      = res_id_q;
                    cnt_d       = '0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_sel    = op_sel_q;
    assign res       = res_q;
    assign res_cout  = res_cout_q;
    assign res_ovf   = res_ovf_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Bench for addsub_share_ctrl: one instance with an ideal shared unit (settle 2) and one
// with a three-cycle-lagged unit (settle 4), both checked against an arithmetic reference.
module tb_addsub_share_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       req0 [2];
    logic       sel0 [2];
    logic       req1 [2];
    logic       sel1 [2];
    logic [3:0] a0 [2];
    logic [3:0] b0 [2];
    logic [3:0] a1 [2];
    logic [3:0] b1 [2];

    typedef struct packed {
        logic       busy;
        logic       gnt0;
        logic       gnt1;
        logic [3:0] op_a;
        logic [3:0] op_b;
        logic       op_sel;
        logic [3:0] res;
        logic       res_cout;
        logic       res_ovf;
        logic       res_id;
        logic       res_valid;
    } obs_t;

    obs_t ob [2];

    // Behaviour of the shared adder/subtractor: {cout, S}.
    function automatic logic [4:0] unit_calc(logic [3:0] a, logic [3:0] b, logic sel);
        int r;
        r = sel ? (int'(a) + 16 - int'(b)) : (int'(a) + int'(b));
        return 5'(r);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int S = (g == 0) ? 2 : 4;
        logic       gnt0, gnt1, op_sel, res_cout, res_ovf, res_id, res_valid, busy, cout_in;
        logic [3:0] op_a, op_b, s_in, res;

        if (g == 0) begin : g_ideal
            assign {cout_in, s_in} = unit_calc(op_a, op_b, op_sel);
        end else begin : g_lag
            logic [4:0] d1 = '0;
            logic [4:0] d2 = '0;
            logic [4:0] d3 = '0;
            always @(posedge clk) begin
                d1 <= unit_calc(op_a, op_b, op_sel);
                d2 <= d1;
                d3 <= d2;
            end
            assign {cout_in, s_in} = d3;
        end

        addsub_share_ctrl #(.SETTLE_CYCLES(S)) dut (
            .clk(clk), .rst(rst),
            .req0(req0[g]), .a0(a0[g]), .b0(b0[g]), .sel0(sel0[g]),
            .req1(req1[g]), .a1(a1[g]), .b1(b1[g]), .sel1(sel1[g]),
            .gnt0(gnt0), .gnt1(gnt1),
            .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
            .s_in(s_in), .cout_in(cout_in),
            .res(res), .res_cout(res_cout), .res_ovf(res_ovf),
            .res_id(res_id), .res_valid(res_valid), .busy(busy)
        );

        assign ob[g] = {busy, gnt0, gnt1, op_a, op_b, op_sel,
                        res, res_cout, res_ovf, res_id, res_valid};
    end

    // Reference arithmetic on plain integers.
    function automatic int ref_res(int a, int b, int sel);
        int r;
        r = sel ? a - b : a + b;
        return ((r % 16) + 16) % 16;
    endfunction

    function automatic int ref_cout(int a, int b, int sel);
        return sel ? int'(a >= b) : int'(a + b > 15);
    endfunction

    function automatic int ref_ovf(int a, int b, int sel);
        int sa, sb, r;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        r  = sel ? sa - sb : sa + sb;
        return int'(r > 7 || r < -8);
    endfunction

    function automatic int settle_of(int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int op_pack(int d);
        return int'({ob[d].op_a, ob[d].op_b, ob[d].op_sel});
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int d, input int ch, input int a, input int b, input int sel,
                          input logic rq);
        if (ch == 0) begin
            a0[d] = 4'(a); b0[d] = 4'(b); sel0[d] = 1'(sel); req0[d] = rq;
        end else begin
            a1[d] = 4'(a); b1[d] = 4'(b); sel1[d] = 1'(sel); req1[d] = rq;
        end
    endtask

    task automatic wait_valid(input int d, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ob[d].res_valid && n < limit);
        if (!ob[d].res_valid) chk("valid_timeout", 0, 1);
    endtask

    // Single-channel operation through the full handshake, checked cycle by cycle.
    task automatic run_op(input int d, input int ch, input int a, input int b, input int sel,
                          output int r, output int c, output int o);
        int n;
        int stable;
        int opx;
        opx = (a << 5) | (b << 1) | sel;
        set_ch(d, ch, a, b, sel, 1'b1);
        tick();
        chk("grant", int'(ch ? ob[d].gnt1 : ob[d].gnt0), 1);
        chk("grant_other", int'(ch ? ob[d].gnt0 : ob[d].gnt1), 0);
        chk("op_load", op_pack(d), opx);
        chk("busy_exec", int'(ob[d].busy), 1);
        n = 0;
        stable = 1;
        while (!ob[d].res_valid && n < 20) begin
            tick();
            n++;
            if (op_pack(d) != opx) stable = 0;
        end
        chk("latency", n, settle_of(d));
        chk("op_stable", stable, 1);
        chk("res", int'(ob[d].res), ref_res(a, b, sel));
        chk("res_cout", int'(ob[d].res_cout), ref_cout(a, b, sel));
        chk("res_ovf", int'(ob[d].res_ovf), ref_ovf(a, b, sel));
        chk("res_id", int'(ob[d].res_id), ch);
        chk("gnt_done", int'(ch ? ob[d].gnt1 : ob[d].gnt0), 1);
        r = int'(ob[d].res);
        c = int'(ob[d].res_cout);
        o = int'(ob[d].res_ovf);
        set_ch(d, ch, a, b, sel, 1'b0);
        tick();
        chk("valid_pulse", int'(ob[d].res_valid), 0);
        chk("busy_idle", int'(ob[d].busy), 0);
        chk("gnt_release", int'(ob[d].gnt0 | ob[d].gnt1), 0);
        chk("res_hold", int'(ob[d].res), ref_res(a, b, sel));
    endtask

    int tbl_a   [5] = '{5, 10, 10, 10, 10};
    int tbl_b   [5] = '{10, 10, 10, 5, 5};
    int tbl_s   [5] = '{1, 0, 1, 0, 1};
    int tbl_r   [5] = '{11, 4, 0, 15, 5};
    int tbl_c   [5] = '{0, 1, 1, 0, 1};
    int tbl_o   [5] = '{1, 1, 0, 0, 1};

    initial begin
        int r, c, o, n, k, overlap, seen_v, seen_g;
        for (int d = 0; d < 2; d++) begin
            set_ch(d, 0, 0, 0, 0, 1'b0);
            set_ch(d, 1, 0, 0, 0, 1'b0);
        end
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outputs_s2", int'(ob[0]), 0);
        chk("reset_outputs_s4", int'(ob[1]), 0);
        rst = 1'b0;

        run_op(0, 0, 5, 10, 0, r, c, o);
        chk("first_res", r, 15);
        chk("first_cout", c, 0);
        chk("first_ovf", o, 0);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 5; i++) begin
                run_op(d, 1, tbl_a[i], tbl_b[i], tbl_s[i], r, c, o);
                chk("tbl_res", r, tbl_r[i]);
                chk("tbl_cout", c, tbl_c[i]);
                chk("tbl_ovf", o, tbl_o[i]);
            end
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                run_op(d, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), r, c, o);
            end
        end

        // Both channels requesting continuously from reset alternate 0,1,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ch(0, 0, 3, 4, 0, 1'b1);
        set_ch(0, 1, 9, 2, 1, 1'b1);
        for (k = 0; k < 4; k++) begin
            n = 0;
            overlap = 0;
            do begin
                tick();
                n++;
                if (ob[0].gnt0 && ob[0].gnt1) overlap = 1;
            end while (!ob[0].res_valid && n < 30);
            chk("dual_lat", n, (k == 0) ? 3 : 4);
            chk("dual_overlap", overlap, 0);
            chk("dual_id", int'(ob[0].res_id), k % 2);
            chk("dual_res", int'(ob[0].res), (k % 2) ? ref_res(9, 2, 1) : ref_res(3, 4, 0));
        end
        set_ch(0, 0, 3, 4, 0, 1'b0);
        set_ch(0, 1, 9, 2, 1, 1'b0);
        tick();

        // Serve channel 0 so the pointer favours channel 1, then abort an op with reset.
        run_op(0, 0, 1, 1, 0, r, c, o);
        set_ch(0, 0, 5, 3, 0, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_async", int'(ob[0]), 0);
        set_ch(0, 0, 5, 3, 0, 1'b0);
        tick();
        rst = 1'b0;
        seen_v = 0;
        seen_g = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ob[0].res_valid) seen_v = 1;
            if (ob[0].gnt0 || ob[0].gnt1) seen_g = 1;
        end
        chk("rst_no_valid", seen_v, 0);
        chk("rst_no_grant", seen_g, 0);
        set_ch(0, 0, 5, 3, 0, 1'b1);
        set_ch(0, 1, 2, 6, 1, 1'b1);
        tick();
        chk("rst_dual_gnt0", int'(ob[0].gnt0), 1);
        chk("rst_dual_gnt1", int'(ob[0].gnt1), 0);
        wait_valid(0, 20, n);
        chk("rst_dual_id", int'(ob[0].res_id), 0);
        chk("rst_dual_res", int'(ob[0].res), 8);
        set_ch(0, 0, 5, 3, 0, 1'b0);
        set_ch(0, 1, 2, 6, 1, 1'b0);
        tick();

        // Request withdrawn during EXEC still completes; a request raised in DONE waits.
        set_ch(0, 0, 7, 9, 1, 1'b1);
        tick();
        chk("drop_gnt0", int'(ob[0].gnt0), 1);
        set_ch(0, 0, 7, 9, 1, 1'b0);
        wait_valid(0, 20, n);
        chk("drop_lat", n, 2);
        chk("drop_res", int'(ob[0].res), 14);
        chk("drop_cout", int'(ob[0].res_cout), 0);
        chk("drop_id", int'(ob[0].res_id), 0);
        set_ch(0, 1, 6, 6, 0, 1'b1);
        tick();
        chk("done_ignore_gnt1", int'(ob[0].gnt1), 0);
        chk("done_ignore_busy", int'(ob[0].busy), 0);
        tick();
        chk("idle_grant_gnt1", int'(ob[0].gnt1), 1);
        chk("idle_grant_op_a", int'(ob[0].op_a), 6);
        wait_valid(0, 20, n);
        chk("late_res", int'(ob[0].res), 12);
        chk("late_id", int'(ob[0].res_id), 1);
        set_ch(0, 1, 6, 6, 0, 1'b0);
        tick();
        chk("late_idle", int'(ob[0].busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_share_ctrl.md
Name: addsub_share_ctrl

Overview:
- Sequencing arbiter that shares one 4-bit adder/subtractor between two requesters (channel 0, channel 1).
- Arbitrates round-robin and registers the winner's operands onto the shared unit's inputs.
- Waits a programmable settle time so the gate-delay variant of the adder/subtractor resolves, then captures the sum, carry and a computed signed-overflow flag.
- Sits between the two operand sources and the shared adder_subtractor_4bit / adder_subtractor_4bit_delay instance.

Parameters:
- SETTLE_CYCLES, 2, number of EXEC cycles operands are held stable before capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req0  input  1  channel 0 request; a0/b0/sel0 must be stable while req0 is high
- a0  input  4  channel 0 operand A
- b0  input  4  channel 0 operand B
- sel0  input  1  channel 0 op: 0 = A+B, 1 = A-B
- req1  input  1  channel 1 request
- a1  input  4  channel 1 operand A
- b1  input  4  channel 1 operand B
- sel1  input  1  channel 1 op select
- gnt0  output  1  channel 0 owns the shared unit (EXEC and DONE)
- gnt1  output  1  channel 1 owns the shared unit
- op_a  output  4  registered A driven to the shared unit
- op_b  output  4  registered B driven to the shared unit
- op_sel  output  1  registered sel driven to the shared unit
- s_in  input  4  S returned from the shared unit
- cout_in  input  1  cout returned from the shared unit
- res  output  4  captured result
- res_cout  output  1  captured carry (for sel=1: 1 = no borrow, A>=B unsigned)
- res_ovf  output  1  two's-complement overflow of the captured op
- res_id  output  1  channel that produced res
- res_valid  output  1  one-cycle pulse; res, res_cout, res_ovf and res_id are valid
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - All outputs = 0.
  - Settle counter = 0.
  - Last-served pointer = 1, so channel 0 wins first.
  - Reset mid-operation aborts the op: no res_valid and no grant after release.
- States and transitions:
  - IDLE -> EXEC on any sampled request.
  - EXEC -> DONE after SETTLE_CYCLES cycles.
  - DONE -> IDLE unconditionally.
- IDLE:
  - Sample req0/req1.
  - Only one requesting: grant it.
  - Both requesting: grant the channel that is not the last-served pointer.
  - On the grant edge: load op_a/op_b/op_sel from the winner's a/b/sel, set gntN=1, set res_id=N, load counter = SETTLE_CYCLES, go to EXEC.
- EXEC:
  - op_* held constant; counter decrements each edge.
  - On the edge where counter==1: capture res=s_in, res_cout=cout_in, and res_ovf.
  - res_ovf for sel=0: (op_a[3]==op_b[3]) && (s_in[3]!=op_a[3]).
  - res_ovf for sel=1: (op_a[3]!=op_b[3]) && (s_in[3]!=op_a[3]).
  - Same edge: set res_valid=1, update last-served = res_id, go to DONE.
- DONE:
  - res_valid=1 for exactly this cycle; gntN stays high.
  - Requests are ignored.
  - Next edge: res_valid=0, gnt0=gnt1=0, go to IDLE.
  - res, res_cout, res_ovf and res_id hold until the next capture.
- Handshake:
  - A requester holds req and operands until it sees res_valid with res_id equal to its channel.
  - It drops req on the following cycle.
  - A req still high in IDLE is a new request, arbitrated normally.
- Latency and throughput:
  - Request sampled at edge 0 -> res_valid high in cycle SETTLE_CYCLES+1.
  - One op every SETTLE_CYCLES+2 cycles.
- A requester dropping req during EXEC does not cancel the op; it completes and pulses res_valid.
- Arithmetic is 4-bit modulo; no width extension; the controller never computes the sum itself.
- gnt0 and gnt1 are never high simultaneously.

Test Plan:
- Reset, then req0 with a0=5, b0=10, sel0=0, SETTLE_CYCLES=2 -> gnt0 at edge 1; res_valid in cycle 3 with res=15, res_cout=0, res_ovf=0, res_id=0; busy low at edge 4.
- Channel 1 sequence a1/b1/sel1 = 5/10/1, 10/10/0, 10/10/1, 10/5/0, 10/5/1 -> (res, cout, ovf) = (11,0,1), (4,1,1), (0,1,0), (15,0,0), (5,1,1), all with res_id=1.
- req0 and req1 high together from reset and held -> grant order 0,1,0,1; each res_valid carries the alternating res_id; gnt never overlaps.
- rst asserted mid-EXEC -> all outputs 0 immediately; no res_valid afterwards; next dual request grants channel 0.
- SETTLE_CYCLES=4 with the delay model connected -> op_* stable for 4 cycles; captured res matches the ideal adder for every operand pair in the sequence above.
- req0 dropped during EXEC -> op still completes with res_valid; req1 raised in DONE -> ignored in DONE, granted from the following IDLE cycle.
